// File: rtl/vec_pkg.sv
// Shared types for the vector multiply-accumulate engine: operation modes and FSM states.
package vec_pkg;

   typedef enum logic [1:0] {
      MODE_DOT    = 2'b00,
      MODE_MUL    = 2'b01,
      MODE_AFFINE = 2'b10,
      MODE_RSVD   = 2'b11
   } mode_e;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD_A  = 3'd1,
      ST_LOAD_B  = 3'd2,
      ST_COMPUTE = 3'd3,
      ST_OUTPUT  = 3'd4
   } state_e;

   function automatic logic is_reserved(input logic [1:0] mode);
      return mode == MODE_RSVD;
   endfunction

endpackage

// File: rtl/vec_lane_alu.sv
// Per-element datapath: one WIDTH-bit product feeding the DOT/MUL/AFFINE result mux.
module vec_lane_alu
   import vec_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  mode_e            mode_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [WIDTH-1:0] bias_i,
   input  logic [WIDTH-1:0] acc_i,
   output logic [WIDTH-1:0] res_o
);

   logic [WIDTH-1:0] prod;

   // Every intermediate is WIDTH bits, so all arithmetic wraps modulo 2^WIDTH.
   always_comb begin
      prod = a_i * b_i;
      case (mode_i)
         MODE_DOT:    res_o = acc_i + prod;
         MODE_MUL:    res_o = prod;
         MODE_AFFINE: res_o = prod + bias_i - b_i;
         default:     res_o = prod;
      endcase
   end

endmodule

// File: rtl/vec_mac_engine.sv
// Vector MAC engine: streams in A and B, computes DOT/MUL/AFFINE one element per cycle,
// streams results out.
//
// state      | meaning
// IDLE       | waiting for start; done/err pulses appear here
// LOAD_A     | accepting LEN words into a[]
// LOAD_B     | accepting LEN words into b[]
// COMPUTE    | one element per cycle, LEN cycles
// OUTPUT     | presenting results on the out stream
module vec_mac_engine
   import vec_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int LEN   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] bias,
   input  logic             abort,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam int IW = $clog2(LEN);
   localparam logic [IW-1:0] LAST_IDX = IW'(LEN - 1);

   state_e           state_q, state_d;
   mode_e            mode_q, mode_d;
   logic [WIDTH-1:0] bias_q, bias_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic [WIDTH-1:0] a_q [LEN];
   logic [WIDTH-1:0] b_q [LEN];
   logic [WIDTH-1:0] r_q [LEN];

   logic             in_fire;
   logic             out_fire;
   logic             last_idx;
   logic             advance;
   logic [WIDTH-1:0] alu_res;

   vec_lane_alu #(
      .WIDTH (WIDTH)
   ) u_alu (
      .mode_i (mode_q),
      .a_i    (a_q[idx_q]),
      .b_i    (b_q[idx_q]),
      .bias_i (bias_q),
      .acc_i  (acc_q),
      .res_o  (alu_res)
   );

   assign in_ready  = (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B);
   assign out_valid = (state_q == ST_OUTPUT);
   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;
   assign err       = err_q;
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;
   assign last_idx  = (idx_q == LAST_IDX);

   // Gated to zero outside OUTPUT so stale storage never leaks onto the port.
   always_comb begin
      out_data = '0;
      if (state_q == ST_OUTPUT) begin
         out_data = (mode_q == MODE_DOT) ? acc_q : r_q[idx_q];
      end
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      bias_d  = bias_q;
      acc_d   = acc_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      advance = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (is_reserved(mode)) begin
                  err_d = 1'b1;
               end else begin
                  mode_d  = mode_e'(mode);
                  bias_d  = bias;
                  acc_d   = '0;
                  state_d = ST_LOAD_A;
               end
            end
         end
         ST_LOAD_A: begin
            advance = in_fire;
            if (in_fire && last_idx) state_d = ST_LOAD_B;
         end
         ST_LOAD_B: begin
            advance = in_fire;
            if (in_fire && last_idx) state_d = ST_COMPUTE;
         end
         ST_COMPUTE: begin
            advance = 1'b1;
            if (mode_q == MODE_DOT) acc_d = alu_res;
            if (last_idx) state_d = ST_OUTPUT;
         end
         ST_OUTPUT: begin
            advance = out_fire;
            if (out_fire && ((mode_q == MODE_DOT) || last_idx)) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Abort overrides any handshake completing on the same edge.
      if (abort && (state_q != ST_IDLE)) begin
         state_d = ST_IDLE;
         done_d  = 1'b0;
      end

      if (state_d != state_q) begin
         idx_d = '0;
      end else if (advance) begin
         idx_d = idx_q + 1'b1;
      end else begin
         idx_d = idx_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         mode_q  <= MODE_DOT;
         bias_q  <= '0;
         acc_q   <= '0;
         idx_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         bias_q  <= bias_d;
         acc_q   <= acc_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // Storage is not reset; it is only visible in OUTPUT after being rewritten.
   always_ff @(posedge clk) begin
      if (in_fire && (state_q == ST_LOAD_A)) a_q[idx_q] <= in_data;
      if (in_fire && (state_q == ST_LOAD_B)) b_q[idx_q] <= in_data;
      if ((state_q == ST_COMPUTE) && (mode_q != MODE_DOT)) r_q[idx_q] <= alu_res;
   end

endmodule

// File: tb/tb_vec_mac_engine.sv
// Directed bench for vec_mac_engine with an arithmetic reference model and a per-cycle output checker.
module tb_vec_mac_engine;

   localparam int W = 8;
   localparam int L = 4;

   typedef int vec_t [L];

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [1:0]   mode = 2'b00;
   logic [W-1:0] bias = '0;
   logic         abort = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_data = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_data;
   logic         busy;
   logic         done;
   logic         err;

   int checks = 0;
   int passes = 0;
   int exp_q[$];
   int got_q[$];

   always #5 clk = ~clk;

   vec_mac_engine #(.WIDTH(W), .LEN(L)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .mode      (mode),
      .bias      (bias),
      .abort     (abort),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain integer arithmetic reduced modulo 2^W.
   task automatic model_calc(input int md, input int bs, input vec_t a, input vec_t b,
                             output vec_t res, output int n);
      int sum;
      res = '{default: 0};
      if (md == 0) begin
         sum = 0;
         for (int i = 0; i < L; i++) sum += a[i] * b[i];
         res[0] = sum % 256;
         n = 1;
      end else begin
         for (int i = 0; i < L; i++) begin
            if (md == 1) res[i] = (a[i] * b[i]) % 256;
            else         res[i] = (((a[i] * b[i] + bs - b[i]) % 256) + 256) % 256;
         end
         n = L;
      end
   endtask

   task automatic send_word(input int w, input bit gaps);
      int n = 0;
      if (gaps && ($urandom_range(0, 1) == 1)) begin
         in_valid = 1'b0;
         repeat ($urandom_range(1, 2)) step();
      end
      in_valid = 1'b1;
      in_data  = W'(w);
      while (!in_ready && n < 50) begin
         step();
         n++;
      end
      if (n >= 50) chk("in_ready timeout", 0, 1);
      step();
      in_valid = 1'b0;
   endtask

   task automatic run_op(input int md, input int bs, input vec_t a, input vec_t b,
                         input bit gaps, input bit stall, input string tag);
      vec_t res;
      int   n;
      int   cnt;
      model_calc(md, bs, a, b, res, n);
      for (int i = 0; i < n; i++) exp_q.push_back(res[i]);
      got_q.delete();
      start = 1'b1;
      mode  = 2'(md);
      bias  = W'(bs);
      step();
      start = 1'b0;
      chk({tag, " busy after start"}, busy, 1);
      chk({tag, " done single pulse"}, done, 0);
      for (int k = 0; k < 2 * L; k++) send_word((k < L) ? a[k] : b[k - L], gaps);
      cnt = 0;
      while (!out_valid && cnt < 4 * L) begin
         step();
         cnt++;
      end
      chk({tag, " compute latency"}, cnt, L);
      for (int k = 0; k < n; k++) begin
         if (stall) begin
            out_ready = 1'b0;
            repeat (5) step();
         end
         out_ready = 1'b1;
         step();
      end
      out_ready = 1'b0;
      chk({tag, " done after last result"}, done, 1);
      chk({tag, " idle after last result"}, busy, 0);
      chk({tag, " all results consumed"}, exp_q.size(), 0);
   endtask

   task automatic chk_got(input string tag, input vec_t lit, input int n);
      chk({tag, " result count"}, got_q.size(), n);
      for (int i = 0; i < n && i < got_q.size(); i++) chk({tag, " literal result"}, got_q[i], lit[i]);
   endtask

   // Output checker: every consumed result against the model, and hold-stability under backpressure.
   logic         pv = 1'b0;
   logic         pr = 1'b0;
   logic [W-1:0] pd = '0;
   always @(negedge clk) begin
      if (!reset) begin
         if (out_valid && pv && !pr) chk("out_data stable while stalled", out_data, pd);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("unexpected result", 1, 0);
            else chk("result vs model", out_data, exp_q.pop_front());
            got_q.push_back(int'(out_data));
         end
         if (in_ready && !busy) chk("in_ready while idle", 1, 0);
      end
      pv = out_valid;
      pr = out_ready;
      pd = out_data;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t va, vb, v16, v255, v1, vz;
      va   = '{1, 2, 3, 4};
      vb   = '{5, 6, 7, 8};
      v16  = '{16, 16, 16, 16};
      v255 = '{255, 255, 255, 255};
      v1   = '{1, 1, 1, 1};
      vz   = '{0, 0, 0, 0};

      #2;
      chk("reset in_ready", in_ready, 0);
      chk("reset out_valid", out_valid, 0);
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset err", err, 0);
      chk("reset out_data", out_data, 0);
      repeat (2) step();
      reset = 1'b0;
      step();

      run_op(0, 0, va, vb, 1'b0, 1'b0, "dot");
      chk_got("dot", '{70, 0, 0, 0}, 1);
      run_op(1, 0, va, vb, 1'b0, 1'b0, "mul");
      chk_got("mul", '{5, 12, 21, 32}, L);
      run_op(2, 10, va, vb, 1'b0, 1'b0, "affine");
      chk_got("affine", '{10, 16, 24, 34}, L);
      run_op(1, 0, v16, v16, 1'b0, 1'b0, "mul wrap");
      chk_got("mul wrap", vz, L);
      run_op(0, 0, v16, v16, 1'b0, 1'b0, "dot wrap");
      chk_got("dot wrap", vz, 1);
      run_op(0, 0, v255, v1, 1'b0, 1'b0, "dot 255");
      chk_got("dot 255", '{252, 0, 0, 0}, 1);
      run_op(2, 10, va, vb, 1'b1, 1'b1, "affine bp");
      chk_got("affine bp", '{10, 16, 24, 34}, L);
      run_op(0, 0, va, vb, 1'b1, 1'b1, "dot bp");
      chk_got("dot bp", '{70, 0, 0, 0}, 1);

      // Abort after three A words, colliding with a fourth transfer on the same edge.
      step();
      start = 1'b1;
      mode  = 2'b00;
      step();
      start = 1'b0;
      for (int k = 0; k < 3; k++) send_word(va[k], 1'b0);
      in_valid = 1'b1;
      in_data  = 8'd9;
      abort    = 1'b1;
      step();
      abort    = 1'b0;
      in_valid = 1'b0;
      chk("abort busy", busy, 0);
      chk("abort in_ready", in_ready, 0);
      chk("abort out_valid", out_valid, 0);
      chk("abort no done", done, 0);
      step();
      chk("abort no done later", done, 0);
      run_op(1, 0, va, vb, 1'b0, 1'b0, "after abort");
      chk_got("after abort", '{5, 12, 21, 32}, L);

      // Asynchronous reset in the middle of COMPUTE.
      step();
      start = 1'b1;
      mode  = 2'b01;
      step();
      start = 1'b0;
      for (int k = 0; k < 2 * L; k++) send_word((k < L) ? va[k] : vb[k - L], 1'b0);
      step();
      chk("computing busy", busy, 1);
      reset = 1'b1;
      #1;
      chk("async reset busy", busy, 0);
      chk("async reset out_valid", out_valid, 0);
      chk("async reset in_ready", in_ready, 0);
      chk("async reset done", done, 0);
      chk("async reset err", err, 0);
      chk("async reset out_data", out_data, 0);
      step();
      reset = 1'b0;
      step();

      start = 1'b1;
      mode  = 2'b11;
      step();
      start = 1'b0;
      chk("reserved err pulse", err, 1);
      chk("reserved stays idle", busy, 0);
      step();
      chk("err one cycle", err, 0);
      chk("reserved still idle", busy, 0);

      run_op(0, 0, va, vb, 1'b0, 1'b0, "after reset");
      chk_got("after reset", '{70, 0, 0, 0}, 1);
      step();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
